// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// id width helper and the register-port request bundle.
package irq_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_PRIO    = 3'd3;
  localparam logic [2:0] ADDR_THRESH  = 3'd4;
  localparam logic [2:0] ADDR_CLAIM   = 3'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  // One extra bit so that id+1 (the CLAIM encoding) always fits.
  function automatic int id_w(input int n_src);
    return $clog2(n_src) + 1;
  endfunction

  localparam int ID_W = id_w(4);

  typedef struct packed {
    logic        en;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational arbiter: highest priority among eligible sources wins,
// ties resolve to the lowest index.
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int PRIO_W = 2,
  parameter int IW     = 3
) (
  input  logic [N_SRC-1:0]        eligible,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [IW-1:0]           id
);

  logic [PRIO_W-1:0] best;

  // Strict '>' keeps the earlier (lower) index on equal priority.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    best  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > best)) begin
        valid = 1'b1;
        id    = IW'(i);
        best  = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level pending capture, enable/priority/threshold
// arbitration and a claim/complete handshake with a single in-service source.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int PRIO_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  src_i,
  input  logic              reg_en_i,
  input  logic              reg_we_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_ready_o,
  output logic              irq_o
);

  localparam int IW     = id_w(N_SRC);
  localparam int PW_ALL = N_SRC * PRIO_W;

  reg_req_t req;
  assign req = '{en: reg_en_i, we: reg_we_i, addr: reg_addr_i, wdata: reg_wdata_i};

  logic [N_SRC-1:0]  src_q, pend_edge_q, enable_q, mode_q;
  logic [PW_ALL-1:0] prio_q;
  logic [PRIO_W-1:0] thresh_q;
  logic [IW-1:0]     active_q;
  state_e            state_q, state_d;
  logic              irq_q, irq_d, ready_q;
  logic [31:0]       rdata_q, rdata_d;

  logic [N_SRC-1:0]  pending, eligible, edge_set, edge_clr, pend_edge_d, cand_oh;
  logic              cand_valid;
  logic [IW-1:0]     cand_id;
  logic              wr, rd, claim_hit, complete;

  assign wr = req.en & req.we;
  assign rd = req.en & ~req.we;

  // Level sources mirror the synchronised line; edge sources are sticky.
  assign pending = (pend_edge_q & mode_q) | (src_q & ~mode_q);

  for (genvar i = 0; i < N_SRC; i++) begin : g_elig
    assign eligible[i] = pending[i] & enable_q[i] &
                         (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
  end

  irq_prio_sel #(.N_SRC(N_SRC), .PRIO_W(PRIO_W), .IW(IW)) u_sel (
    .eligible (eligible),
    .prio     (prio_q),
    .valid    (cand_valid),
    .id       (cand_id)
  );

  assign claim_hit = rd && req.addr == ADDR_CLAIM && state_q == ST_IDLE && cand_valid;
  assign complete  = wr && req.addr == ADDR_CLAIM && state_q == ST_SERVICE &&
                     req.wdata == 32'(active_q) + 32'd1;

  assign cand_oh  = N_SRC'(1) << cand_id;
  assign edge_set = src_i & ~src_q & mode_q;
  assign edge_clr = ((wr && req.addr == ADDR_PENDING) ? req.wdata[N_SRC-1:0] : '0) |
                    (claim_hit ? cand_oh : '0);
  // Set after clear: a new edge coinciding with a clear keeps the bit.
  assign pend_edge_d = ((pend_edge_q & ~edge_clr) | edge_set) & mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (claim_hit) state_d = ST_SERVICE;
      ST_SERVICE: if (complete)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A claim in this cycle withdraws the request at the next edge.
  always_comb begin
    irq_d = (state_q == ST_IDLE) && cand_valid && !claim_hit;
  end

  always_comb begin
    rdata_d = '0;
    case (req.addr)
      ADDR_PENDING: rdata_d[N_SRC-1:0]  = pending;
      ADDR_ENABLE:  rdata_d[N_SRC-1:0]  = enable_q;
      ADDR_MODE:    rdata_d[N_SRC-1:0]  = mode_q;
      ADDR_PRIO:    rdata_d[PW_ALL-1:0] = prio_q;
      ADDR_THRESH:  rdata_d[PRIO_W-1:0] = thresh_q;
      ADDR_CLAIM:   if (state_q == ST_IDLE && cand_valid) rdata_d = 32'(cand_id) + 32'd1;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q       <= '0;
      pend_edge_q <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      prio_q      <= '0;
      thresh_q    <= '0;
      active_q    <= '0;
      irq_q       <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      src_q       <= src_i;
      pend_edge_q <= pend_edge_d;
      irq_q       <= irq_d;
      ready_q     <= req.en;
      rdata_q     <= rd ? rdata_d : '0;
      if (claim_hit) active_q <= cand_id;
      if (wr) begin
        case (req.addr)
          ADDR_ENABLE: enable_q <= req.wdata[N_SRC-1:0];
          ADDR_MODE:   mode_q   <= req.wdata[N_SRC-1:0];
          ADDR_PRIO:   prio_q   <= req.wdata[PW_ALL-1:0];
          ADDR_THRESH: thresh_q <= req.wdata[PRIO_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ready_o = ready_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register table plus hand-written claim,
// complete, level, threshold, set-priority and reset sequences.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src;
  logic        en, we;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready, irq;
  int          n_pass = 0, n_tot = 0;

  irq_ctrl #(.N_SRC(4), .PRIO_W(2)) dut (
    .clk(clk), .rst(rst), .src_i(src),
    .reg_en_i(en), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rdata_o(rdata), .reg_ready_o(ready), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); en = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); en = 1'b0;
    chk(name, rdata, exp);
  endtask

  task automatic pulse(input logic [3:0] s);
    @(negedge clk); src = s;
    @(negedge clk); src = 4'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tbl_result(input int j);
    chk($sformatf("tbl[%0d] ready", j), {31'd0, ready}, 32'd1);
    if (!tbl[j].we) chk($sformatf("tbl[%0d] rdata", j), rdata, tbl[j].exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0]  = '{1'b0, ADDR_ENABLE,  32'h0,         32'h0};
    tbl[1]  = '{1'b0, ADDR_MODE,    32'h0,         32'h0};
    tbl[2]  = '{1'b0, ADDR_PRIO,    32'h0,         32'h0};
    tbl[3]  = '{1'b0, ADDR_THRESH,  32'h0,         32'h0};
    tbl[4]  = '{1'b0, ADDR_PENDING, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, ADDR_ENABLE,  32'hFFFF_FFF5, 32'h0};
    tbl[6]  = '{1'b0, ADDR_ENABLE,  32'h0,         32'h5};
    tbl[7]  = '{1'b1, ADDR_MODE,    32'hA,         32'h0};
    tbl[8]  = '{1'b0, ADDR_MODE,    32'h0,         32'hA};
    tbl[9]  = '{1'b1, ADDR_PRIO,    32'h1E4,       32'h0};
    tbl[10] = '{1'b0, ADDR_PRIO,    32'h0,         32'hE4};
    tbl[11] = '{1'b1, ADDR_THRESH,  32'hE,         32'h0};
    tbl[12] = '{1'b0, ADDR_THRESH,  32'h0,         32'h2};
    tbl[13] = '{1'b1, 3'd6,         32'h1234,      32'h0};
    tbl[14] = '{1'b0, 3'd6,         32'h0,         32'h0};
    tbl[15] = '{1'b0, 3'd7,         32'h0,         32'h0};
    tbl[16] = '{1'b0, ADDR_CLAIM,   32'h0,         32'h0};
    tbl[17] = '{1'b1, ADDR_PENDING, 32'hF,         32'h0};
    tbl[18] = '{1'b0, ADDR_PENDING, 32'h0,         32'h0};

    rst = 1'b0; src = 4'h0; en = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'h0;
    cycles(3);
    chk("reset irq",   {31'd0, irq},   32'd0);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst = 1'b1;
    cycles(1);

    // Back-to-back table: result of vector i-1 is visible while i is driven.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i > 0) tbl_result(i - 1);
      en = 1'b1; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
    end
    @(negedge clk);
    tbl_result(18);
    en = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ready drops", {31'd0, ready}, 32'd0);

    // Basic edge claim/complete on src2.
    wr(ADDR_ENABLE, 32'hF); wr(ADDR_MODE, 32'hF); wr(ADDR_PRIO, 32'h55); wr(ADDR_THRESH, 32'h0);
    @(negedge clk); src = 4'h4;
    @(negedge clk); chk("edge irq not yet", {31'd0, irq}, 32'd0); src = 4'h0;
    @(negedge clk); chk("edge irq", {31'd0, irq}, 32'd1);
    rd_chk("edge claim", ADDR_CLAIM, 32'd3);
    chk("irq drop after claim", {31'd0, irq}, 32'd0);
    rd_chk("pending cleared by claim", ADDR_PENDING, 32'd0);
    wr(ADDR_CLAIM, 32'd3);

    // Equal priority tie goes to lower index.
    pulse(4'h6); cycles(1);
    rd_chk("tie claim", ADDR_CLAIM, 32'd2);
    wr(ADDR_CLAIM, 32'd2);
    rd_chk("tie next claim", ADDR_CLAIM, 32'd3);
    wr(ADDR_CLAIM, 32'd3);

    // Priority order and wrong-id complete.
    wr(ADDR_PRIO, 32'hD5);
    pulse(4'h9); cycles(1);
    chk("prio irq", {31'd0, irq}, 32'd1);
    rd_chk("prio claim", ADDR_CLAIM, 32'd4);
    wr(ADDR_CLAIM, 32'd2);
    rd_chk("wrong id keeps service", ADDR_CLAIM, 32'd0);
    chk("no irq in service", {31'd0, irq}, 32'd0);
    wr(ADDR_CLAIM, 32'd4);
    rd_chk("second claim", ADDR_CLAIM, 32'd1);
    wr(ADDR_CLAIM, 32'd1);
    cycles(2);
    chk("idle no irq", {31'd0, irq}, 32'd0);

    // Level source survives claim and complete.
    wr(ADDR_MODE, 32'hD); wr(ADDR_PRIO, 32'h55);
    @(negedge clk); src = 4'h2;
    cycles(2);
    chk("level irq", {31'd0, irq}, 32'd1);
    rd_chk("level claim", ADDR_CLAIM, 32'd2);
    chk("level irq drop", {31'd0, irq}, 32'd0);
    rd_chk("level pending kept", ADDR_PENDING, 32'h2);
    wr(ADDR_CLAIM, 32'd2);
    cycles(2);
    chk("level irq reassert", {31'd0, irq}, 32'd1);
    @(negedge clk); src = 4'h0;
    rd_chk("level pending follows src", ADDR_PENDING, 32'h0);
    chk("level irq gone", {31'd0, irq}, 32'd0);
    wr(ADDR_MODE, 32'hF);

    // Threshold gating and live config change.
    wr(ADDR_PRIO, 32'h56); wr(ADDR_THRESH, 32'd2);
    pulse(4'h1); cycles(3);
    chk("thresh blocks", {31'd0, irq}, 32'd0);
    rd_chk("thresh pending", ADDR_PENDING, 32'h1);
    wr(ADDR_THRESH, 32'd1);
    k = 0;
    while (irq !== 1'b1 && k < 3) begin
      @(negedge clk); k++;
    end
    chk("thresh lowered irq", {31'd0, irq}, 32'd1);
    chk("thresh latency", (k <= 2) ? 32'd1 : 32'd0, 32'd1);
    rd_chk("thresh claim", ADDR_CLAIM, 32'd1);
    wr(ADDR_CLAIM, 32'd1);
    wr(ADDR_THRESH, 32'd0);

    // New edge coinciding with W1C keeps the bit; plain W1C clears it.
    @(negedge clk); src = 4'h8; en = 1'b1; we = 1'b1; addr = ADDR_PENDING; wdata = 32'h8;
    @(negedge clk); en = 1'b0; we = 1'b0;
    rd_chk("set beats w1c", ADDR_PENDING, 32'h8);
    src = 4'h0;
    wr(ADDR_PENDING, 32'h8);
    rd_chk("w1c clears", ADDR_PENDING, 32'h0);

    // Reset in SERVICE with an access in flight.
    pulse(4'h8); cycles(1);
    rd_chk("svc claim", ADDR_CLAIM, 32'd4);
    wr(ADDR_CLAIM, 32'd2);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = ADDR_ENABLE;
    #2 rst = 1'b0;
    @(negedge clk); en = 1'b0;
    chk("rst ready", {31'd0, ready}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst irq",   {31'd0, irq},   32'd0);
    rst = 1'b1;
    cycles(1);
    rd_chk("rst enable cleared", ADDR_ENABLE, 32'd0);
    wr(ADDR_ENABLE, 32'hF); wr(ADDR_MODE, 32'hF); wr(ADDR_PRIO, 32'h55);
    pulse(4'h4); cycles(1);
    rd_chk("post-reset idle claim", ADDR_CLAIM, 32'd3);
    wr(ADDR_CLAIM, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
